// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode line transmitter and its receiver-side benches.
package barcode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Level the barcode line rests at between frames.
  localparam logic BC_IDLE_LVL = 1'b1;

  // Default bit-cell length in clocks, shared with the receiver testbench.
  localparam int unsigned BC_DEFAULT_PERIOD = 1024;

endpackage

// File: rtl/barcode_cell_timer.sv
// Loadable down-counter timing one phase (low, high or gap) of a barcode cell.
module barcode_cell_timer #(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  // Load a phase length minus one, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Terminal count: the current clock is the last one of the phase.
  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/barcode_tx.sv
// Barcode line transmitter: sends an 8-bit ID MSB first as pulse-width-coded cells.
module barcode_tx #(
  parameter int unsigned PER_W      = 22,
  parameter int unsigned MIN_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [7:0]       ID,
  input  logic [PER_W-1:0] period,
  output logic             BC,
  output logic             busy,
  output logic             done
);

  import barcode_pkg::*;

  state_t           state_q, state_d;
  logic [7:0]       id_q;
  logic [PER_W-1:0] per_q, q1_q, q0_q;
  logic [2:0]       idx_q;
  logic             bc_q, busy_q, done_q, gap_end_q;

  logic [PER_W-1:0] in_per_c, in_q1_c, in_q0_c;
  logic [PER_W-1:0] cur_low_c, nxt_low_c;
  logic             accept_c, capture_c, idx_dec_c, gap_end_c;
  logic             ld_c, tc_c;
  logic [PER_W-1:0] ld_val_c;
  logic             bc_c, busy_c;

  // Clamp the requested period and split it into short (q1) and long (q0) low times.
  always_comb begin
    in_per_c = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;
    in_q1_c  = in_per_c >> 2;
    in_q0_c  = in_per_c - in_q1_c;
  end

  // Low time of the bit in flight and of the next bit down.
  always_comb begin
    cur_low_c = id_q[idx_q] ? q1_q : q0_q;
    nxt_low_c = id_q[idx_q - 3'd1] ? q1_q : q0_q;
  end

  assign accept_c = send & ~busy_q & (state_q == IDLE);

  // Next-state logic; every phase change reloads the cell timer.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    idx_dec_c = 1'b0;
    gap_end_c = 1'b0;
    ld_c      = 1'b0;
    ld_val_c  = '0;
    bc_c      = BC_IDLE_LVL;
    busy_c    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          capture_c = 1'b1;
          state_d   = LOW;
          ld_c      = 1'b1;
          ld_val_c  = (ID[7] ? in_q1_c : in_q0_c) - PER_W'(1);
        end
      end
      LOW: begin
        bc_c = ~BC_IDLE_LVL;
        if (tc_c) begin
          state_d  = HIGH;
          ld_c     = 1'b1;
          ld_val_c = per_q - cur_low_c - PER_W'(1);
        end
      end
      HIGH: begin
        if (tc_c) begin
          ld_c = 1'b1;
          if (idx_q == 3'd0) begin
            state_d  = GAP;
            ld_val_c = per_q - PER_W'(1);
          end else begin
            state_d   = LOW;
            idx_dec_c = 1'b1;
            ld_val_c  = nxt_low_c - PER_W'(1);
          end
        end
      end
      GAP: begin
        if (tc_c) begin
          state_d   = IDLE;
          gap_end_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Holding registers for the frame in flight and the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q  <= '0;
      per_q <= '0;
      q1_q  <= '0;
      q0_q  <= '0;
      idx_q <= '0;
    end else if (capture_c) begin
      id_q  <= ID;
      per_q <= in_per_c;
      q1_q  <= in_q1_c;
      q0_q  <= in_q0_c;
      idx_q <= 3'd7;
    end else if (idx_dec_c) begin
      idx_q <= idx_q - 3'd1;
    end
  end

  // Output registers; done is delayed one more clock so it follows the last gap clock on BC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q      <= BC_IDLE_LVL;
      busy_q    <= 1'b0;
      gap_end_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bc_q      <= bc_c;
      busy_q    <= busy_c;
      gap_end_q <= gap_end_c;
      done_q    <= gap_end_q;
    end
  end

  barcode_cell_timer #(.W(PER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_c),
    .load_val (ld_val_c),
    .tc_c     (tc_c)
  );

  assign BC   = bc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_barcode_tx.sv
// Self-checking bench for barcode_tx: vector table, random frames, and corner sequences.
module tb_barcode_tx;
  import barcode_pkg::*;

  localparam int PW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          send = 1'b0;
  logic [7:0]    ID = '0;
  logic [PW-1:0] period = '0;
  logic          BC, busy, done;

  barcode_tx #(.PER_W(PW), .MIN_PERIOD(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .send   (send),
    .ID     (ID),
    .period (period),
    .BC     (BC),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         meas_err, meas_lat, first_t;
  int         meas_lows[8];
  logic [2:0] first_act, first_exp;

  typedef struct {
    logic [7:0] id;
    int         per;
    int         q1;
    int         q0;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int eff(input int p);
    return (p < 8) ? 8 : p;
  endfunction

  // Expected {BC,busy,done} t clocks after the edge that sampled send.
  function automatic logic [2:0] model(input logic [7:0] id, input int per, input int t);
    int p, n, pos, q1, q0, low;
    p = eff(per);
    if (t >= 1 && t <= 8 * p) begin
      n   = (t - 1) / p;
      pos = (t - 1) % p;
      q1  = p / 4;
      q0  = p - q1;
      low = id[7 - n] ? q1 : q0;
      return {(pos < low) ? 1'b0 : 1'b1, 1'b1, 1'b0};
    end else if (t > 8 * p && t <= 9 * p) begin
      return 3'b110;
    end else if (t == 9 * p + 1) begin
      return 3'b101;
    end
    return 3'b100;
  endfunction

  task automatic pulse_send(input logic [7:0] id, input int p);
    @(negedge clk);
    send   = 1'b1;
    ID     = id;
    period = PW'(p);
    @(negedge clk);
    send   = 1'b0;
    ID     = 8'($urandom);
    period = PW'($urandom_range(4, 200));
  endtask

  // Observe one frame cycle by cycle against the model; starts right after the sampling edge.
  task automatic watch(input logic [7:0] id, input int per, input int extra);
    logic [2:0] act, exp;
    int p;
    p        = eff(per);
    meas_err = 0;
    meas_lat = -1;
    first_t  = -1;
    for (int i = 0; i < 8; i++) meas_lows[i] = 0;
    for (int t = 1; t <= 9 * p + 1 + extra; t++) begin
      @(posedge clk);
      #1;
      act = {BC, busy, done};
      exp = model(id, per, t);
      if (act !== exp) begin
        meas_err++;
        if (first_t < 0) begin
          first_t   = t;
          first_act = act;
          first_exp = exp;
        end
      end
      if (done === 1'b1 && meas_lat < 0) meas_lat = t;
      if (t <= 8 * p && BC === 1'b0) meas_lows[(t - 1) / p]++;
    end
  endtask

  task automatic wave_check(input string name);
    n_checks++;
    if (meas_err != 0) begin
      n_fail++;
      $display("FAIL %s: %0d cycles differ, first at t=%0d got {BC,busy,done}=%b expected %b",
               name, meas_err, first_t, first_act, first_exp);
    end
  endtask

  vec_t tbl[7];

  initial begin
    int bad, pulses;
    logic [7:0] rid;
    int rp;

    tbl[0] = '{id: 8'h25, per: 64,                     q1: 16,  q0: 48,  lat: 577};
    tbl[1] = '{id: 8'h3A, per: int'(BC_DEFAULT_PERIOD), q1: 256, q0: 768, lat: 9217};
    tbl[2] = '{id: 8'hC1, per: 32,                     q1: 8,   q0: 24,  lat: 289};
    tbl[3] = '{id: 8'h00, per: 4,                      q1: 2,   q0: 6,   lat: 73};
    tbl[4] = '{id: 8'hFF, per: 10,                     q1: 2,   q0: 8,   lat: 91};
    tbl[5] = '{id: 8'hA5, per: 0,                      q1: 2,   q0: 6,   lat: 73};
    tbl[6] = '{id: 8'h5A, per: 9,                      q1: 2,   q0: 7,   lat: 82};

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", int'({BC, busy, done}), 3'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle for 100 clocks with no request.
    bad = 0;
    pulses = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (BC !== 1'b1 || busy !== 1'b0) bad++;
      if (done === 1'b1) pulses++;
    end
    check("idle_line_busy", bad, 0);
    check("idle_done_pulses", pulses, 0);

    // Vector table: latency and per-cell low widths.
    for (int v = 0; v < 7; v++) begin
      pulse_send(tbl[v].id, tbl[v].per);
      watch(tbl[v].id, tbl[v].per, 2);
      wave_check($sformatf("vec%0d_wave", v));
      check($sformatf("vec%0d_latency", v), meas_lat, tbl[v].lat);
      for (int n = 0; n < 8; n++)
        check($sformatf("vec%0d_cell%0d_low", v, n), meas_lows[n],
              tbl[v].id[7 - n] ? tbl[v].q1 : tbl[v].q0);
    end

    // Random frames, including sub-minimum and non-multiple-of-4 periods.
    for (int r = 0; r < 8; r++) begin
      rid = 8'($urandom);
      rp  = $urandom_range(1, 48);
      pulse_send(rid, rp);
      watch(rid, rp, 2);
      wave_check($sformatf("rand%0d_wave_id%02h_p%0d", r, rid, rp));
      check($sformatf("rand%0d_latency", r), meas_lat, 9 * eff(rp) + 1);
    end

    // Send during a frame is ignored; send in the done cycle starts the next frame.
    pulse_send(8'h96, 16);
    fork
      watch(8'h96, 16, 0);
      begin
        repeat (40) @(negedge clk);
        send   = 1'b1;
        ID     = 8'h0F;
        period = PW'(8);
        @(negedge clk);
        send   = 1'b0;
      end
    join
    wave_check("ignored_send_wave");
    check("ignored_send_latency", meas_lat, 145);
    check("done_cycle_busy", int'(busy), 0);
    send   = 1'b1;
    ID     = 8'h6C;
    period = PW'(16);
    @(posedge clk);
    #1;
    send   = 1'b0;
    watch(8'h6C, 16, 2);
    wave_check("b2b_wave");
    check("b2b_latency", meas_lat, 145);

    // Reset in the middle of bit 4 of a period-32 frame.
    pulse_send(8'h00, 32);
    repeat (133) @(posedge clk);
    #1;
    check("pre_reset_bc", int'(BC), 0);
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", int'({BC, busy, done}), 3'b100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if ({BC, busy, done} !== 3'b100) bad++;
    end
    check("no_resume_after_reset", bad, 0);
    pulse_send(8'h5B, 32);
    watch(8'h5B, 32, 2);
    wave_check("post_reset_wave");
    check("post_reset_latency", meas_lat, 289);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
